// File: rtl/dac_pkg.sv
// Shared definitions for the serial DAC transmitter.
//   dac_state_t      : transmitter FSM states
//   STATUS_*         : codes reported on the status output, one per state
//   FRAME_BITS       : bits per DAC frame, {ctrl[3:0], sample[11:0]}
//   DEFAULT_MIDSCALE : audio-zero sample replayed until real data arrives
//   status_of()      : maps a state to its status code
package dac_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    LATCH
  } dac_state_t;

  localparam logic [7:0] STATUS_IDLE  = 8'h00;
  localparam logic [7:0] STATUS_SETUP = 8'h01;
  localparam logic [7:0] STATUS_SHIFT = 8'h02;
  localparam logic [7:0] STATUS_HOLD  = 8'h03;
  localparam logic [7:0] STATUS_LATCH = 8'h04;

  localparam int FRAME_BITS = 16;

  localparam logic [11:0] DEFAULT_MIDSCALE = 12'h800;

  function automatic logic [7:0] status_of(input dac_state_t s);
    case (s)
      IDLE:    return STATUS_IDLE;
      SETUP:   return STATUS_SETUP;
      SHIFT:   return STATUS_SHIFT;
      HOLD:    return STATUS_HOLD;
      LATCH:   return STATUS_LATCH;
      default: return STATUS_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/dac_tx_if.sv
// Sample delivery channel from the processor to the DAC transmitter.
//   sample_in    : 12-bit unsigned audio sample
//   sample_valid : producer has a sample on sample_in
//   sample_ready : consumer holding register is empty
// Handshake: a transfer happens on every clock edge where sample_valid and
// sample_ready are both high. The producer keeps sample_in stable and
// sample_valid high until that edge; sample_ready does not depend on
// sample_valid in the same cycle.
// Modports: master = processor side, slave = dac_tx.
interface dac_tx_if;
  logic [11:0] sample_in;
  logic        sample_valid;
  logic        sample_ready;

  modport master (
    output sample_in,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  sample_in,
    input  sample_valid,
    output sample_ready
  );
endinterface

// File: rtl/dac_tx_tick_gen.sv
// tick_gen: free-running divider producing a one-cycle tick.
//   clk, reset : system clock, synchronous active-high reset
//   enable     : count when high; counter is held at 0 when low
//   tick       : high for one cycle when the counter wraps at DIV-1
// Shared with the ADC capture side, so it carries no DAC-specific logic.
module tick_gen #(
  parameter int DIV = 12500
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Gated by enable so dropping enable suppresses a tick in the same cycle.
  assign tick = enable && (cnt == LAST);

endmodule

// File: rtl/dac_tx.sv
// dac_tx: serial DAC transmitter.
// Buffers one 12-bit sample from the processor and, on every sample tick,
// shifts {ctrl, sample} MSB first to an SPI-style DAC, then pulses LDAC.
// Ports:
//   clk, reset    : system clock, synchronous active-high reset
//   enable        : run the sample tick generator
//   ctrl          : DAC control nibble, captured at frame load
//   smp           : sample valid/ready channel (slave side)
//   dac_cs_n      : chip select, active low
//   dac_sclk      : serial clock, idle low
//   dac_din       : serial data, changes on SCLK fall
//   dac_ldac_n    : load strobe, active low
//   busy          : FSM not in IDLE
//   underrun_cnt  : saturating count of ticks that found no fresh sample
//   status        : current state code (STATUS_* in dac_pkg)
// Frame timing, one phase = CLK_DIV cycles:
//   SETUP(1) + SHIFT(16 high + 15 low) + HOLD(1) + LATCH(1) = 34 phases.
module dac_tx
  import dac_pkg::*;
#(
  parameter int          CLK_DIV    = 50,
  parameter int          SAMPLE_DIV = 12500,
  parameter logic [11:0] MIDSCALE   = DEFAULT_MIDSCALE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] ctrl,
  dac_tx_if.slave    smp,
  output logic       dac_cs_n,
  output logic       dac_sclk,
  output logic       dac_din,
  output logic       dac_ldac_n,
  output logic       busy,
  output logic [7:0] underrun_cnt,
  output logic [7:0] status
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PH_LAST  = PW'(CLK_DIV - 1);
  localparam logic [4:0]    LAST_BIT = 5'(FRAME_BITS - 1);

  // ---------------------------------------------------------------- tick
  logic tick;

  tick_gen #(
    .DIV(SAMPLE_DIV)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .enable(enable),
    .tick  (tick)
  );

  // ------------------------------------------------------ sample holding
  logic [11:0] hold;
  logic        hold_full;
  logic [11:0] last_sample;
  logic        xfer;
  logic        load;
  logic [11:0] load_data;

  dac_state_t state, state_nxt;

  assign smp.sample_ready = !hold_full;
  assign xfer      = smp.sample_valid && !hold_full;
  // Ticks outside IDLE are dropped entirely: no load, no underrun.
  assign load      = tick && (state == IDLE);
  // A same-cycle transfer is not bypassed; the tick sees the old contents.
  assign load_data = hold_full ? hold : last_sample;

  always_ff @(posedge clk) begin
    if (reset) begin
      hold         <= '0;
      hold_full    <= 1'b0;
      last_sample  <= MIDSCALE;
      underrun_cnt <= '0;
    end else begin
      // xfer needs an empty register and a consuming load needs a full
      // one, so the two never collide.
      if (load && hold_full) begin
        hold_full <= 1'b0;
      end
      if (xfer) begin
        hold        <= smp.sample_in;
        hold_full   <= 1'b1;
        last_sample <= smp.sample_in;
      end
      if (load && !hold_full && (underrun_cnt != 8'hFF)) begin
        underrun_cnt <= underrun_cnt + 8'd1;
      end
    end
  end

  // ----------------------------------------------------------------- FSM
  logic [PW-1:0]         phase, phase_nxt;
  logic [4:0]            bit_cnt, bit_cnt_nxt;
  logic [FRAME_BITS-1:0] shreg, shreg_nxt;
  logic                  cs_n_nxt, sclk_nxt, din_nxt, ldac_n_nxt;
  logic                  busy_nxt;
  logic [7:0]            status_nxt;
  logic                  phase_end;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      phase      <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      dac_cs_n   <= 1'b1;
      dac_sclk   <= 1'b0;
      dac_din    <= 1'b0;
      dac_ldac_n <= 1'b1;
      busy       <= 1'b0;
      status     <= STATUS_IDLE;
    end else begin
      state      <= state_nxt;
      phase      <= phase_nxt;
      bit_cnt    <= bit_cnt_nxt;
      shreg      <= shreg_nxt;
      dac_cs_n   <= cs_n_nxt;
      dac_sclk   <= sclk_nxt;
      dac_din    <= din_nxt;
      dac_ldac_n <= ldac_n_nxt;
      busy       <= busy_nxt;
      status     <= status_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    phase_nxt   = phase;
    bit_cnt_nxt = bit_cnt;
    shreg_nxt   = shreg;
    cs_n_nxt    = dac_cs_n;
    sclk_nxt    = dac_sclk;
    din_nxt     = dac_din;
    ldac_n_nxt  = dac_ldac_n;
    phase_end   = (phase == PH_LAST);

    case (state)
      IDLE: begin
        if (load) begin
          state_nxt   = SETUP;
          phase_nxt   = '0;
          bit_cnt_nxt = LAST_BIT;
          shreg_nxt   = {ctrl, load_data};
          cs_n_nxt    = 1'b0;
          sclk_nxt    = 1'b0;
          din_nxt     = ctrl[3];
        end
      end

      SETUP: begin
        if (phase_end) begin
          state_nxt = SHIFT;
          phase_nxt = '0;
          sclk_nxt  = 1'b1;
        end else begin
          phase_nxt = phase + PW'(1);
        end
      end

      SHIFT: begin
        if (phase_end) begin
          phase_nxt = '0;
          if (dac_sclk) begin
            sclk_nxt = 1'b0;
            if (bit_cnt == 5'd0) begin
              state_nxt = HOLD;
            end else begin
              // Present the next bit while SCLK is low.
              bit_cnt_nxt = bit_cnt - 5'd1;
              shreg_nxt   = {shreg[FRAME_BITS-2:0], 1'b0};
              din_nxt     = shreg[FRAME_BITS-2];
            end
          end else begin
            sclk_nxt = 1'b1;
          end
        end else begin
          phase_nxt = phase + PW'(1);
        end
      end

      HOLD: begin
        if (phase_end) begin
          state_nxt  = LATCH;
          phase_nxt  = '0;
          cs_n_nxt   = 1'b1;
          ldac_n_nxt = 1'b0;
        end else begin
          phase_nxt = phase + PW'(1);
        end
      end

      LATCH: begin
        if (phase_end) begin
          state_nxt  = IDLE;
          phase_nxt  = '0;
          ldac_n_nxt = 1'b1;
          din_nxt    = 1'b0;
        end else begin
          phase_nxt = phase + PW'(1);
        end
      end

      default: begin
        state_nxt  = IDLE;
        phase_nxt  = '0;
        cs_n_nxt   = 1'b1;
        sclk_nxt   = 1'b0;
        din_nxt    = 1'b0;
        ldac_n_nxt = 1'b1;
      end
    endcase

    // Registered alongside the pins so status and busy line up with them.
    busy_nxt   = (state_nxt != IDLE);
    status_nxt = status_of(state_nxt);
  end

endmodule

// File: tb/tb_dac_tx.sv
// Testbench for dac_tx with small dividers (CLK_DIV=2, SAMPLE_DIV=80).
// A behavioural model predicts ticks, frames, underruns and the pin levels
// from elapsed time inside a frame; a scoreboard compares frames captured
// on SCLK rises against the model's expected queue.
module tb_dac_tx;
  import dac_pkg::*;

  localparam int CD    = 2;
  localparam int SD    = 80;
  localparam int FRAME = 34 * CD;

  // ------------------------------------------------------ clock / reset
  logic       clk    = 1'b0;
  logic       reset  = 1'b1;
  logic       enable = 1'b0;
  logic [3:0] ctrl   = 4'h4;

  logic       dac_cs_n, dac_sclk, dac_din, dac_ldac_n, busy;
  logic [7:0] underrun_cnt, status;

  always #5 clk = ~clk;

  dac_tx_if smp ();

  dac_tx #(
    .CLK_DIV   (CD),
    .SAMPLE_DIV(SD),
    .MIDSCALE  (12'h800)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .ctrl        (ctrl),
    .smp         (smp),
    .dac_cs_n    (dac_cs_n),
    .dac_sclk    (dac_sclk),
    .dac_din     (dac_din),
    .dac_ldac_n  (dac_ldac_n),
    .busy        (busy),
    .underrun_cnt(underrun_cnt),
    .status      (status)
  );

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ------------------------------------------------------------ checker
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ----------------------------------------------------- reference model
  int          m_cnt   = 0;
  int          m_left  = 0;
  logic        m_full  = 1'b0;
  logic [11:0] m_hold  = '0;
  logic [11:0] m_last  = 12'h800;
  int          m_under = 0;
  logic [15:0] m_frame = '0;
  logic        m_tick, m_full0, m_idle0;
  logic [15:0] exp_q[$];

  always @(posedge clk) begin
    if (reset) begin
      m_cnt   = 0;
      m_left  = 0;
      m_full  = 1'b0;
      m_hold  = '0;
      m_last  = 12'h800;
      m_under = 0;
      exp_q.delete();
    end else begin
      m_tick  = enable && (m_cnt == SD - 1);
      m_full0 = m_full;
      m_idle0 = (m_left == 0);
      if (m_tick && m_idle0) begin
        m_frame = {ctrl, m_full0 ? m_hold : m_last};
        exp_q.push_back(m_frame);
        if (m_full0) m_full = 1'b0;
        else if (m_under < 255) m_under++;
        m_left = FRAME;
      end else if (m_left > 0) begin
        m_left--;
      end
      if (smp.sample_valid && !m_full0) begin
        m_hold = smp.sample_in;
        m_last = smp.sample_in;
        m_full = 1'b1;
      end
      m_cnt = enable ? ((m_cnt == SD - 1) ? 0 : m_cnt + 1) : 0;
    end
  end

  // ------------------------------------------------- monitor/scoreboard
  logic        prev_sclk = 1'b0;
  logic        prev_cs   = 1'b1;
  logic [15:0] cap       = '0;
  int          cap_bits  = 0;
  int          frames_done = 0;
  logic [15:0] last_frame  = '0;
  int          cs_falls    = 0;
  int          cs_low_run  = 0;
  int          last_cs_low = 0;
  int          e_ph, e_idx;
  logic        e_cs, e_sclk, e_din, e_ldac, e_busy;
  logic [7:0]  e_status;

  always @(posedge clk) begin
    #1;
    if (m_left == 0) begin
      e_cs = 1'b1; e_sclk = 1'b0; e_din = 1'b0; e_ldac = 1'b1;
      e_busy = 1'b0; e_status = STATUS_IDLE;
    end else begin
      e_ph   = (FRAME - m_left) / CD;
      e_busy = 1'b1;
      e_cs   = (e_ph >= 33);
      e_ldac = (e_ph != 33);
      e_sclk = (e_ph >= 1) && (e_ph <= 31) && (e_ph % 2 == 1);
      e_idx  = (e_ph <= 31) ? 15 - e_ph / 2 : 0;
      e_din  = m_frame[e_idx];
      e_status = (e_ph == 0) ? STATUS_SETUP :
                 (e_ph <= 31) ? STATUS_SHIFT :
                 (e_ph == 32) ? STATUS_HOLD : STATUS_LATCH;
    end
    check("pin_cs_n", 32'(dac_cs_n), 32'(e_cs));
    check("pin_sclk", 32'(dac_sclk), 32'(e_sclk));
    check("pin_din", 32'(dac_din), 32'(e_din));
    check("pin_ldac_n", 32'(dac_ldac_n), 32'(e_ldac));
    check("busy", 32'(busy), 32'(e_busy));
    check("status", 32'(status), 32'(e_status));
    check("sample_ready", 32'(smp.sample_ready), 32'(!m_full));
    check("underrun_cnt", 32'(underrun_cnt), 32'(m_under));

    if (reset) begin
      cap_bits   = 0;
      cap        = '0;
      cs_low_run = 0;
    end else begin
      if (prev_cs && !dac_cs_n) begin
        cs_falls++;
        cap_bits   = 0;
        cs_low_run = 0;
      end
      if (!dac_cs_n) cs_low_run++;
      if (!prev_sclk && dac_sclk && !dac_cs_n) begin
        cap = {cap[14:0], dac_din};
        cap_bits++;
      end
      if (!prev_cs && dac_cs_n) begin
        check("frame_bits", 32'(cap_bits), 32'd16);
        check("frame_pending", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("frame_data", 32'(cap), 32'(exp_q.pop_front()));
        last_frame  = cap;
        last_cs_low = cs_low_run;
        frames_done++;
      end
    end
    prev_sclk = dac_sclk;
    prev_cs   = dac_cs_n;
  end

  // ------------------------------------------------------ driver tasks
  logic [11:0] last_written = 12'h800;

  task automatic write_sample(input logic [11:0] v);
    int n = 0;
    @(negedge clk);
    smp.sample_in    = v;
    smp.sample_valid = 1'b1;
    while (!smp.sample_ready && n < 4 * SD) begin
      @(negedge clk);
      n++;
    end
    check("wr_ready", 32'(smp.sample_ready), 32'd1);
    @(negedge clk);
    smp.sample_valid = 1'b0;
    last_written = v;
  endtask

  task automatic wait_frames(input int target, input string tag);
    int n = 0;
    while (frames_done < target && n < 4 * SD) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(frames_done), 32'(target));
  endtask

  task automatic wait_cs_low(input string tag);
    int n = 0;
    while (dac_cs_n && n < 2 * SD) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(dac_cs_n), 32'd0);
  endtask

  // ------------------------------------------------------------ stimulus
  int target;
  int falls0;

  initial begin
    smp.sample_in    = '0;
    smp.sample_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cs_n", 32'(dac_cs_n), 32'd1);
    check("rst_sclk", 32'(dac_sclk), 32'd0);
    check("rst_din", 32'(dac_din), 32'd0);
    check("rst_ldac_n", 32'(dac_ldac_n), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_status", 32'(status), 32'h00);
    check("rst_underrun", 32'(underrun_cnt), 32'd0);
    check("rst_ready", 32'(smp.sample_ready), 32'd1);

    // First frame replays midscale and counts an underrun.
    reset  = 1'b0;
    enable = 1'b1;
    wait_frames(1, "t1_wait");
    check("t1_frame", 32'(last_frame), 32'h4800);
    check("t1_under", 32'(underrun_cnt), 32'd1);
    check("t1_cs_low_len", 32'(last_cs_low), 32'(33 * CD));

    // Fresh sample goes out, ready returns after the load.
    write_sample(12'hABC);
    check("t2_ready_low", 32'(smp.sample_ready), 32'd0);
    wait_cs_low("t2_cs_wait");
    check("t2_ready_after_load", 32'(smp.sample_ready), 32'd1);
    wait_frames(2, "t2_wait");
    check("t2_frame", 32'(last_frame), 32'h4ABC);
    check("t2_under", 32'(underrun_cnt), 32'd1);

    // One sample then three starved ticks.
    write_sample(12'h123);
    for (int i = 0; i < 4; i++) begin
      wait_frames(3 + i, "t3_wait");
      check("t3_frame", 32'(last_frame), 32'h4123);
    end
    check("t3_under", 32'(underrun_cnt), 32'd4);

    // Transfer on the exact tick cycle is not bypassed.
    begin
      int n = 0;
      while (m_cnt != SD - 1 && n < 2 * SD) begin
        @(negedge clk);
        n++;
      end
      check("t4_align", 32'(m_cnt), 32'(SD - 1));
    end
    smp.sample_in    = 12'h5A5;
    smp.sample_valid = 1'b1;
    @(negedge clk);
    smp.sample_valid = 1'b0;
    last_written = 12'h5A5;
    wait_frames(7, "t4_wait_a");
    check("t4_frame_old", 32'(last_frame), 32'h4123);
    check("t4_under", 32'(underrun_cnt), 32'd5);
    wait_frames(8, "t4_wait_b");
    check("t4_frame_new", 32'(last_frame), 32'h45A5);
    check("t4_under_b", 32'(underrun_cnt), 32'd5);

    // Randomized traffic against the model.
    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, SD)) @(negedge clk);
      ctrl = 4'($urandom_range(0, 15));
      write_sample(12'($urandom_range(0, 4095)));
    end
    repeat (2 * SD) @(negedge clk);

    // Long starvation saturates the counter.
    ctrl = 4'h4;
    repeat (300 * SD) @(negedge clk);
    check("t6_under_sat", 32'(underrun_cnt), 32'd255);
    check("t6_frame", 32'(last_frame), 32'({4'h4, last_written}));

    // Reset mid-frame aborts immediately.
    wait_cs_low("t7_cs_wait");
    repeat (24) @(negedge clk);
    target = frames_done + 1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("t7_cs_n", 32'(dac_cs_n), 32'd1);
    check("t7_sclk", 32'(dac_sclk), 32'd0);
    check("t7_ldac_n", 32'(dac_ldac_n), 32'd1);
    check("t7_status", 32'(status), 32'h00);
    @(negedge clk);
    reset = 1'b0;
    wait_frames(target, "t7_wait");
    check("t7_frame_mid", 32'(last_frame), 32'h4800);
    check("t7_under", 32'(underrun_cnt), 32'd1);

    // Dropping enable mid-frame lets the frame finish, then silence.
    wait_cs_low("t8_cs_wait");
    target = frames_done + 1;
    repeat (10) @(negedge clk);
    enable = 1'b0;
    wait_frames(target, "t8_wait");
    check("t8_cs_low_len", 32'(last_cs_low), 32'(33 * CD));
    check("t8_frame", 32'(last_frame), 32'h4800);
    falls0 = cs_falls;
    repeat (3 * SD) @(negedge clk);
    check("t8_no_frames", 32'(cs_falls), 32'(falls0));
    check("t8_idle", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/dac_tx.md
Name: dac_tx

Overview:
- Serial DAC transmitter for the effects pedal output path. It is the output-direction counterpart of the ADC capture controller.
- Accepts processed 12-bit audio samples from the Wishbone-side processor through a valid/ready handshake and buffers one sample.
- On every sample tick (4 kHz default) it shifts one 16-bit frame, {ctrl[3:0], sample[11:0]}, MSB first, to an external SPI-style DAC. It then pulses the DAC load strobe.

Parameters:
- CLK_DIV, 50, clk cycles per SCLK phase (high or low); 50 MHz clk gives 500 kHz SCLK.
- SAMPLE_DIV, 12500, clk cycles between sample ticks (4 kHz). Must satisfy SAMPLE_DIV > 34*CLK_DIV + 2.
- MIDSCALE, 12'h800, sample replayed after reset (audio zero).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- enable  in  1  run the tick generator; when low, no new frames start
- ctrl  in  4  DAC control nibble; sampled when a frame is loaded
- sample_in  in  12  unsigned audio sample
- sample_valid  in  1  sample_in is valid
- sample_ready  out  1  holding register empty
- dac_cs_n  out  1  DAC chip select, active low
- dac_sclk  out  1  DAC serial clock, idle low
- dac_din  out  1  DAC serial data; changes on SCLK fall, DAC samples on rise
- dac_ldac_n  out  1  DAC load strobe, active low
- busy  out  1  high in any state other than IDLE
- underrun_cnt  out  8  saturating count of ticks that found no fresh sample
- status  out  8  0x00 idle, 0x01 setup, 0x02 shifting, 0x03 hold, 0x04 latch

Behaviour:
- Reset values:
  - dac_cs_n=1, dac_ldac_n=1, dac_sclk=0, dac_din=0, busy=0, status=0x00, underrun_cnt=0.
  - sample_ready=1 (holding register empty), last_sample=MIDSCALE.
  - Tick counter=0, state=IDLE.
- Reset mid-frame aborts the frame immediately: next cycle the outputs hold their reset values.
- Handshake:
  - A transfer happens on any cycle with sample_valid && sample_ready. It writes the holding register and last_sample, and sample_ready drops the next cycle.
  - sample_ready returns high the cycle after a frame load consumes the holding register.
- Tick:
  - While enable=1, the counter counts 0..SAMPLE_DIV-1. A one-cycle tick fires at the wrap.
  - When enable=0 the counter is held at 0.
  - A tick in any state other than IDLE is ignored and not counted.
- Frame load, on a tick in IDLE:
  - Shift register <= {ctrl, hold_full ? hold : last_sample}.
  - If the holding register is empty, underrun_cnt increments and saturates at 255.
  - A transfer on the same cycle as the tick is not bypassed: that tick uses last_sample and counts as an underrun. The new sample goes out on the next tick.
- FSM (each phase lasts CLK_DIV cycles):
  - IDLE -> SETUP on load.
  - SETUP: cs_n=0, sclk=0, din=bit15.
  - SHIFT: 16 high phases and 15 low phases.
    - sclk rises at the start of each bit.
    - At each high-to-low transition for bits 15..1, din advances to the next bit.
    - After the 16th high phase, go to HOLD with sclk=0.
  - HOLD: cs_n=0, sclk=0, din holds bit0.
  - LATCH: cs_n=1, ldac_n=0.
  - LATCH -> IDLE: ldac_n=1, din=0.
  - Frame length is 34*CLK_DIV cycles from load to IDLE (1700 at default).
- enable falling mid-frame: the frame completes normally, and no further ticks occur.
- status and busy are registered and follow the state in the same cycle as the other outputs.
- Widths: the phase counter is sized by $clog2(CLK_DIV), the bit counter is 5 bits, and the tick counter is sized by $clog2(SAMPLE_DIV). No arithmetic on sample data.

Decomposition:
- Package dac_pkg holds:
  - state enum {IDLE, SETUP, SHIFT, HOLD, LATCH};
  - status code constants 0x00–0x04;
  - FRAME_BITS=16;
  - default MIDSCALE.
- Sub-module tick_gen(DIV): free-running divider with enable and a one-cycle tick output. The same block serves the ADC side.

Test Plan:
- Reset, enable=1, no samples, ctrl=4'h4 -> first frame at cycle 12500 shifts 16'h4800; underrun_cnt=1; ldac_n low for 50 cycles starting at cycle 12500+33*50.
- Write 12'hABC, ctrl=4'h4, then the tick -> din bit sequence = 16'h4ABC MSB first, sampled on sclk rises; sample_ready=1 one cycle after the load; underrun_cnt unchanged.
- Write 12'h123, withhold the next sample for 3 ticks -> 16'h4123 sent 4 times; underrun_cnt +3; holding 300 ticks with no data -> saturates at 255.
- Transfer on the exact tick cycle with the holding register empty -> that frame carries the old last_sample and counts an underrun; the next frame carries the new value.
- Assert reset at cycle 600 of a frame -> next cycle cs_n=1, sclk=0, ldac_n=1, status=0x00; the following frame carries MIDSCALE.
- Drop enable mid-frame -> frame completes in 1700 cycles; no further cs_n falling edge during 3*SAMPLE_DIV cycles.
